// File: rtl/fifo_dram_param_if.sv
// Handshake/data bundle between a producer (master) and one fifo_dram_param
// instance (slave).
interface fifo_dram_param_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] datain;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] dataout;
  logic             full_flag;
  logic             empty_flag;
  logic             almost_full;
  logic             almost_empty;
  logic [AW:0]      count;
  logic             overflow;
  logic             underflow;

  modport master (
    output datain, wr_en, rd_en,
    input  dataout, full_flag, empty_flag, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  datain, wr_en, rd_en,
    output dataout, full_flag, empty_flag, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/fifo_dram_param.sv
// Parametrised synchronous FIFO with exact occupancy count, threshold flags,
// sticky error flags and selectable standard / first-word-fall-through reads.
module fifo_dram_param #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned FWFT      = 0,
  parameter int unsigned AFULL_TH  = DEPTH - 1,
  parameter int unsigned AEMPTY_TH = 1
) (
  input  logic               clk,
  input  logic               rst,
  fifo_dram_param_if.slave   bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dataout_q, dataout_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             afull_q, afull_d;
  logic             aempty_q, aempty_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             wr_acc;
  logic             rd_acc;

  // Next-state: pointers, occupancy, flags decoded from the next count, read data.
  always_comb begin
    wr_acc      = bus.wr_en && !full_q;
    rd_acc      = bus.rd_en && !empty_q;

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    dataout_d   = dataout_q;
    overflow_d  = overflow_q  || (bus.wr_en && full_q);
    underflow_d = underflow_q || (bus.rd_en && empty_q);

    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);

    if (wr_acc && !rd_acc)      count_d = count_q + CW'(1);
    else if (rd_acc && !wr_acc) count_d = count_q - CW'(1);

    full_d   = (count_d == CW'(DEPTH));
    empty_d  = (count_d == '0);
    afull_d  = (32'(count_d) >= AFULL_TH);
    aempty_d = (32'(count_d) <= AEMPTY_TH);

    // FWFT keeps the next head word registered; a word written this cycle
    // that becomes the head is taken straight from datain.
    if (FWFT != 0) begin
      if (count_d == '0)
        dataout_d = '0;
      else if (wr_acc && (rd_ptr_d == wr_ptr_q))
        dataout_d = bus.datain;
      else
        dataout_d = mem_q[rd_ptr_d];
    end else if (rd_acc) begin
      dataout_d = mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dataout_q   <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      afull_q     <= (AFULL_TH == 0);
      aempty_q    <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      dataout_q   <= dataout_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      afull_q     <= afull_d;
      aempty_q    <= aempty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) mem_q[wr_ptr_q] <= bus.datain;
  end

  assign bus.dataout      = dataout_q;
  assign bus.count        = count_q;
  assign bus.full_flag    = full_q;
  assign bus.empty_flag   = empty_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_dram_param.sv
// Bench for fifo_dram_param: a standard-read DEPTH=8 instance and an FWFT
// DEPTH=16 instance, both checked each cycle against a queue-based model.
module tb_fifo_dram_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1;

  fifo_dram_param_if #(.WIDTH(8), .DEPTH(8))  b0 ();
  fifo_dram_param_if #(.WIDTH(8), .DEPTH(16)) b1 ();

  fifo_dram_param #(.WIDTH(8), .DEPTH(8), .FWFT(0), .AFULL_TH(7), .AEMPTY_TH(1))
    u0 (.clk(clk), .rst(rst0), .bus(b0.slave));
  fifo_dram_param #(.WIDTH(8), .DEPTH(16), .FWFT(1), .AFULL_TH(12), .AEMPTY_TH(3))
    u1 (.clk(clk), .rst(rst1), .bus(b1.slave));

  int n_assert = 0;
  int n_fail   = 0;

  int dep [2] = '{8, 16};
  int fw  [2] = '{0, 1};
  int aft [2] = '{7, 12};
  int aet [2] = '{1, 3};

  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  logic [7:0] mdout [2];
  bit         movf  [2];
  bit         munf  [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: a plain queue with accept/reject rules.
  task automatic model(input int id, input bit w, input bit r, input logic [7:0] d, input bit rs);
    logic [7:0] q [$];
    logic [7:0] popped;
    bit full, empty;
    if (id == 0) q = q0; else q = q1;
    if (rs) begin
      q.delete();
      movf[id]  = 1'b0;
      munf[id]  = 1'b0;
      mdout[id] = 8'h00;
    end else begin
      full  = (q.size() == dep[id]);
      empty = (q.size() == 0);
      if (w && full)  movf[id] = 1'b1;
      if (r && empty) munf[id] = 1'b1;
      if (r && !empty) begin
        popped = q.pop_front();
        if (fw[id] == 0) mdout[id] = popped;
      end
      if (w && !full) q.push_back(d);
      if (fw[id] != 0) mdout[id] = (q.size() != 0) ? q[0] : 8'h00;
    end
    if (id == 0) q0 = q; else q1 = q;
  endtask

  task automatic check(input int id);
    logic [31:0] o_dout, o_cnt;
    logic o_full, o_empty, o_af, o_ae, o_ovf, o_unf;
    int c;
    string p;
    if (id == 0) begin
      o_dout = 32'(b0.dataout); o_cnt = 32'(b0.count);
      o_full = b0.full_flag; o_empty = b0.empty_flag;
      o_af = b0.almost_full; o_ae = b0.almost_empty;
      o_ovf = b0.overflow; o_unf = b0.underflow;
      c = q0.size();
    end else begin
      o_dout = 32'(b1.dataout); o_cnt = 32'(b1.count);
      o_full = b1.full_flag; o_empty = b1.empty_flag;
      o_af = b1.almost_full; o_ae = b1.almost_empty;
      o_ovf = b1.overflow; o_unf = b1.underflow;
      c = q1.size();
    end
    p = $sformatf("u%0d@%0t", id, $time);
    chk({p, ".dataout"},      o_dout,          32'(mdout[id]));
    chk({p, ".count"},        o_cnt,           32'(c));
    chk({p, ".full_flag"},    32'(o_full),     32'(c == dep[id]));
    chk({p, ".empty_flag"},   32'(o_empty),    32'(c == 0));
    chk({p, ".almost_full"},  32'(o_af),       32'(c >= aft[id]));
    chk({p, ".almost_empty"}, 32'(o_ae),       32'(c <= aet[id]));
    chk({p, ".overflow"},     32'(o_ovf),      32'(movf[id]));
    chk({p, ".underflow"},    32'(o_unf),      32'(munf[id]));
  endtask

  // One clock of stimulus on one instance; the other stays idle.
  task automatic cyc(input int id, input bit w, input bit r, input logic [7:0] d, input bit rs);
    if (id == 0) begin b0.wr_en = w; b0.rd_en = r; b0.datain = d; rst0 = rs; end
    else         begin b1.wr_en = w; b1.rd_en = r; b1.datain = d; rst1 = rs; end
    @(posedge clk);
    model(id, w, r, d, rs);
    #1;
    if (id == 0) begin b0.wr_en = 1'b0; b0.rd_en = 1'b0; rst0 = 1'b0; end
    else         begin b1.wr_en = 1'b0; b1.rd_en = 1'b0; rst1 = 1'b0; end
    check(id);
  endtask

  task automatic rand_run(input int id, input int n);
    for (int i = 0; i < n; i++)
      cyc(id, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          8'($urandom), ($urandom_range(0, 63) == 0));
  endtask

  initial begin
    b0.wr_en = 1'b0; b0.rd_en = 1'b0; b0.datain = 8'h00;
    b1.wr_en = 1'b0; b1.rd_en = 1'b0; b1.datain = 8'h00;
    rst0 = 1'b0; rst1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      movf[i] = 1'b0; munf[i] = 1'b0; mdout[i] = 8'h00;
    end

    // Standard-read instance: reset overriding a write, then idle.
    cyc(0, 1'b1, 1'b0, 8'hEE, 1'b1);
    cyc(0, 1'b0, 1'b0, 8'h00, 1'b0);

    // Fill and drain.
    for (int i = 0; i < 8; i++) cyc(0, 1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
    for (int i = 0; i < 8; i++) cyc(0, 1'b0, 1'b1, 8'h00, 1'b0);

    // Wrap-around, three rounds of five.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++) cyc(0, 1'b1, 1'b0, 8'(8'h40 + r * 5 + i), 1'b0);
      for (int i = 0; i < 5; i++) cyc(0, 1'b0, 1'b1, 8'h00, 1'b0);
    end

    // Simultaneous read/write at steady occupancy 4.
    for (int i = 0; i < 4; i++) cyc(0, 1'b1, 1'b0, 8'(8'h60 + i), 1'b0);
    for (int i = 0; i < 10; i++) cyc(0, 1'b1, 1'b1, 8'($urandom), 1'b0);

    // Both at full, refill, then a rejected 0xAA write.
    for (int i = 0; i < 4; i++) cyc(0, 1'b1, 1'b0, 8'(8'h70 + i), 1'b0);
    cyc(0, 1'b1, 1'b1, 8'h55, 1'b0);
    cyc(0, 1'b1, 1'b0, 8'h77, 1'b0);
    cyc(0, 1'b1, 1'b0, 8'hAA, 1'b0);

    // Drain, both at empty, read past empty.
    for (int i = 0; i < 8; i++) cyc(0, 1'b0, 1'b1, 8'h00, 1'b0);
    cyc(0, 1'b1, 1'b1, 8'h66, 1'b0);
    cyc(0, 1'b0, 1'b1, 8'h00, 1'b0);
    cyc(0, 1'b0, 1'b1, 8'h00, 1'b0);
    cyc(0, 1'b0, 1'b0, 8'h00, 1'b0);
    cyc(0, 1'b0, 1'b0, 8'h00, 1'b1);

    rand_run(0, 400);

    // FWFT instance.
    cyc(1, 1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1, 1'b1, 1'b0, 8'h3C, 1'b0);
    cyc(1, 1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1, 1'b0, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1, 1'b1, 1'b0, 8'(8'h80 + i), 1'b0);
    cyc(1, 1'b0, 1'b1, 8'h00, 1'b0);
    cyc(1, 1'b1, 1'b1, 8'h90, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1, 1'b1, 1'b0, 8'(8'hA0 + i), 1'b0);
    cyc(1, 1'b1, 1'b0, 8'hB0, 1'b1);
    cyc(1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 17; i++) cyc(1, 1'b1, 1'b0, 8'(8'hC0 + i), 1'b0);
    cyc(1, 1'b1, 1'b1, 8'hDD, 1'b0);
    for (int i = 0; i < 17; i++) cyc(1, 1'b0, 1'b1, 8'h00, 1'b0);
    cyc(1, 1'b1, 1'b1, 8'hE1, 1'b0);
    cyc(1, 1'b1, 1'b1, 8'hE2, 1'b0);

    rand_run(1, 400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
